// File: rtl/whack_input_encoder.sv
// whack_input_encoder: conditions the five board buttons (sync, debounce,
// press-edge) and turns one clean single-button press into a 3-bit whack
// position with a 1-cycle valid strobe, plus reject / hold-off handling.

// Per-button conditioning: 2-FF sync, debounce, press edge, re-arm gating.
module whack_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 23
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   input  logic settled,
   output logic stable,
   output logic press
);
   logic [1:0]       sync_q, sync_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stable_q, stable_d;
   logic             prev_q, prev_d;
   logic             armed_q, armed_d;

   // Debounce: flip stable only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   // A button is armed only once it has been seen released after reset, so a
   // button held through reset cannot fire until it is re-pressed.
   always_comb begin
      sync_d   = {sync_q[0], raw};
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync_q[1] != stable_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) stable_d = ~stable_q;
         else                                      cnt_d    = cnt_q + 1'b1;
      end
      prev_d  = stable_q;
      armed_d = armed_q | (settled & ~sync_q[1] & ~stable_q);
   end

   // Conditioning state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
         prev_q   <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         prev_q   <= prev_d;
         armed_q  <= armed_d;
      end
   end

   assign stable = stable_q;
   assign press  = stable_q & ~prev_q & armed_q;
endmodule

module whack_input_encoder #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int HOLDOFF_CYCLES  = 5_000_000,
   parameter int CNT_W           = 23
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       left_button,
   input  logic       top_button,
   input  logic       right_button,
   input  logic       bottom_button,
   input  logic       mid_button,
   input  logic       pause,
   output logic       whack_valid,
   output logic [2:0] whack_pos,
   output logic       reject,
   output logic [7:0] press_count,
   output logic       busy
);
   localparam int NUM_BTN = 5;

   typedef enum logic [2:0] {S_IDLE, S_EMIT, S_REJ, S_HOLD, S_WREL} state_t;

   logic [NUM_BTN-1:0] btn_raw, stable, press;
   logic [1:0]         settle_q, settle_d;
   logic               settled, held;
   logic [2:0]         nheld, btn_code;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic               whack_valid_q, whack_valid_d;
   logic               reject_q, reject_d;
   logic [2:0]         whack_pos_q, whack_pos_d;
   logic [7:0]         press_count_q, press_count_d;

   // Bit i is button code i+1.
   assign btn_raw = {mid_button, bottom_button, right_button, top_button, left_button};
   assign settled = (settle_q == 2'd2);

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      whack_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_deb (
         .clk    (clk),
         .rst    (rst),
         .raw    (btn_raw[g]),
         .settled(settled),
         .stable (stable[g]),
         .press  (press[g])
      );
   end

   // Held-button census and position code of the (single) held button.
   always_comb begin
      nheld    = '0;
      btn_code = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         nheld = nheld + {2'b00, stable[i]};
         if (stable[i]) btn_code = 3'(i + 1);
      end
   end

   assign held = |stable;

   // Next-state and registered-output logic for the accept/reject FSM.
   always_comb begin
      settle_d      = settled ? settle_q : settle_q + 2'd1;
      state_d       = state_q;
      hold_cnt_d    = hold_cnt_q;
      whack_valid_d = 1'b0;
      reject_d      = 1'b0;
      whack_pos_d   = whack_pos_q;
      press_count_d = press_count_q;
      case (state_q)
         S_IDLE: begin
            if (!pause && (|press)) begin
               if (nheld > 3'd1) begin
                  state_d  = S_REJ;
                  reject_d = 1'b1;
               end else begin
                  state_d       = S_EMIT;
                  whack_valid_d = 1'b1;
                  whack_pos_d   = btn_code;
                  if (press_count_q != 8'hFF) press_count_d = press_count_q + 8'd1;
               end
            end
         end
         S_EMIT: begin
            state_d    = S_HOLD;
            hold_cnt_d = '0;
         end
         S_REJ:  state_d = S_WREL;
         S_HOLD: begin
            if (!pause) begin
               if (hold_cnt_q == CNT_W'(HOLDOFF_CYCLES - 1)) begin
                  state_d    = S_WREL;
                  hold_cnt_d = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end
         end
         S_WREL: if (!held) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM state and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         settle_q      <= '0;
         state_q       <= S_IDLE;
         hold_cnt_q    <= '0;
         whack_valid_q <= 1'b0;
         reject_q      <= 1'b0;
         whack_pos_q   <= '0;
         press_count_q <= '0;
      end else begin
         settle_q      <= settle_d;
         state_q       <= state_d;
         hold_cnt_q    <= hold_cnt_d;
         whack_valid_q <= whack_valid_d;
         reject_q      <= reject_d;
         whack_pos_q   <= whack_pos_d;
         press_count_q <= press_count_d;
      end
   end

   assign whack_valid = whack_valid_q;
   assign reject      = reject_q;
   assign whack_pos   = whack_pos_q;
   assign press_count = press_count_q;
   assign busy        = (state_q != S_IDLE);
endmodule
